// File: rtl/music_player_ctrl.sv
// Music player sequencer: walks a synchronous song ROM note by note, converts pitch
// codes to tone frequencies and times beats; supports play/pause, stop, next song and looping.
module music_player_ctrl #(
    parameter int BEAT_BASE = 12_500_000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        play_btn,
    input  logic        stop_btn,
    input  logic        next_btn,
    input  logic [1:0]  speed_sel,
    input  logic        loop_en,
    input  logic [7:0]  note_data,
    output logic [12:0] rom_addr,
    output logic [15:0] freq,
    output logic [10:0] index,
    output logic [1:0]  name,
    output logic [1:0]  mode,
    output logic [1:0]  speed,
    output logic        color
);

    typedef enum logic [2:0] {
        ST_STOP,
        ST_FETCH,
        ST_DECODE,
        ST_PLAY,
        ST_PAUSE
    } state_t;

    localparam int TW = $clog2(BEAT_BASE * 2 + 1);

    // Terminal timer values (beat length minus one) for each tempo setting.
    localparam logic [TW-1:0] LAST_00 = TW'(BEAT_BASE - 1);
    localparam logic [TW-1:0] LAST_01 = TW'(BEAT_BASE / 2 - 1);
    localparam logic [TW-1:0] LAST_10 = TW'(BEAT_BASE / 4 - 1);
    localparam logic [TW-1:0] LAST_11 = TW'(BEAT_BASE * 2 - 1);

    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_PLAY  = 2'b01;
    localparam logic [1:0] MODE_PAUSE = 2'b10;

    function automatic logic [15:0] pitch_hz(input logic [3:0] code);
        case (code)
            4'd1:    pitch_hz = 16'd262;
            4'd2:    pitch_hz = 16'd277;
            4'd3:    pitch_hz = 16'd294;
            4'd4:    pitch_hz = 16'd311;
            4'd5:    pitch_hz = 16'd330;
            4'd6:    pitch_hz = 16'd349;
            4'd7:    pitch_hz = 16'd370;
            4'd8:    pitch_hz = 16'd392;
            4'd9:    pitch_hz = 16'd415;
            4'd10:   pitch_hz = 16'd440;
            4'd11:   pitch_hz = 16'd466;
            4'd12:   pitch_hz = 16'd494;
            4'd13:   pitch_hz = 16'd523;
            4'd14:   pitch_hz = 16'd587;
            4'd15:   pitch_hz = 16'd659;
            default: pitch_hz = 16'd0;
        endcase
    endfunction

    state_t         state_reg, state_next;
    logic [10:0]    index_reg, index_next;
    logic [1:0]     name_reg, name_next;
    logic [15:0]    freq_reg, freq_next;
    logic [15:0]    note_freq_reg, note_freq_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic [3:0]     beat_cnt_reg, beat_cnt_next;
    logic           color_reg, color_next;
    logic [1:0]     speed_reg;
    logic [1:0]     mode_reg, mode_next;
    logic [TW-1:0]  last_tick;
    logic           beat_end;
    logic           end_hit;

    always_comb begin
        case (speed_reg)
            2'b01:   last_tick = LAST_01;
            2'b10:   last_tick = LAST_10;
            2'b11:   last_tick = LAST_11;
            default: last_tick = LAST_00;
        endcase
    end

    // Comparing with >= lets a mid-beat switch to a faster tempo end the beat at once.
    assign beat_end = (timer_reg >= last_tick);

    always_comb begin
        state_next     = state_reg;
        index_next     = index_reg;
        name_next      = name_reg;
        freq_next      = freq_reg;
        note_freq_next = note_freq_reg;
        timer_next     = timer_reg;
        beat_cnt_next  = beat_cnt_reg;
        color_next     = color_reg;
        end_hit        = 1'b0;

        if (stop_btn) begin
            state_next = ST_STOP;
            index_next = '0;
        end else begin
            case (state_reg)
                ST_STOP: begin
                    if (next_btn) begin
                        name_next  = name_reg + 2'd1;
                        index_next = '0;
                    end else if (play_btn) begin
                        state_next = ST_FETCH;
                        index_next = '0;
                    end
                end
                ST_FETCH: begin
                    if (next_btn) begin
                        name_next  = name_reg + 2'd1;
                        index_next = '0;
                    end else begin
                        state_next = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (next_btn) begin
                        name_next  = name_reg + 2'd1;
                        index_next = '0;
                        state_next = ST_FETCH;
                    end else if (note_data == 8'h00) begin
                        end_hit = 1'b1;
                    end else begin
                        freq_next      = pitch_hz(note_data[7:4]);
                        note_freq_next = pitch_hz(note_data[7:4]);
                        beat_cnt_next  = (note_data[3:0] == 4'd0) ? 4'd1 : note_data[3:0];
                        timer_next     = '0;
                        state_next     = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (next_btn) begin
                        name_next  = name_reg + 2'd1;
                        index_next = '0;
                        state_next = ST_FETCH;
                    end else if (play_btn) begin
                        state_next = ST_PAUSE;
                        freq_next  = '0;
                    end else if (beat_end) begin
                        timer_next    = '0;
                        color_next    = ~color_reg;
                        beat_cnt_next = beat_cnt_reg - 4'd1;
                        if (beat_cnt_reg <= 4'd1) begin
                            if (index_reg == 11'd2047) begin
                                end_hit = 1'b1;
                            end else begin
                                index_next = index_reg + 11'd1;
                                state_next = ST_FETCH;
                            end
                        end
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (next_btn) begin
                        name_next  = name_reg + 2'd1;
                        index_next = '0;
                        state_next = ST_STOP;
                    end else if (play_btn) begin
                        state_next = ST_PLAY;
                        freq_next  = note_freq_reg;
                    end
                end
                default: state_next = ST_STOP;
            endcase
        end

        if (end_hit) begin
            index_next = '0;
            state_next = loop_en ? ST_FETCH : ST_STOP;
        end

        // Every path into STOP silences the tone and clears the blink.
        if (state_next == ST_STOP) begin
            freq_next  = '0;
            color_next = 1'b0;
        end

        case (state_next)
            ST_STOP:  mode_next = MODE_STOP;
            ST_PAUSE: mode_next = MODE_PAUSE;
            default:  mode_next = MODE_PLAY;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg     <= ST_STOP;
            index_reg     <= '0;
            name_reg      <= '0;
            freq_reg      <= '0;
            note_freq_reg <= '0;
            timer_reg     <= '0;
            beat_cnt_reg  <= '0;
            color_reg     <= 1'b0;
            speed_reg     <= '0;
            mode_reg      <= MODE_STOP;
        end else begin
            state_reg     <= state_next;
            index_reg     <= index_next;
            name_reg      <= name_next;
            freq_reg      <= freq_next;
            note_freq_reg <= note_freq_next;
            timer_reg     <= timer_next;
            beat_cnt_reg  <= beat_cnt_next;
            color_reg     <= color_next;
            speed_reg     <= speed_sel;
            mode_reg      <= mode_next;
        end
    end

    assign rom_addr = {name_reg, index_reg};
    assign freq     = freq_reg;
    assign index    = index_reg;
    assign name     = name_reg;
    assign mode     = mode_reg;
    assign speed    = speed_reg;
    assign color    = color_reg;

endmodule

// File: tb/tb_music_player_ctrl.sv
// Directed bench for music_player_ctrl with BEAT_BASE=8 and a 1-cycle-latency song ROM;
// k in comments counts negedge observations after the edge that captured play_btn.
module tb_music_player_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic        play_btn, stop_btn, next_btn;
    logic [1:0]  speed_sel;
    logic        loop_en;
    logic [7:0]  note_data;
    logic [12:0] rom_addr;
    logic [15:0] freq;
    logic [10:0] index;
    logic [1:0]  name;
    logic [1:0]  mode;
    logic [1:0]  speed;
    logic        color;

    int vecs = 0;
    int errs = 0;

    logic [7:0] rom [0:8191];

    music_player_ctrl #(.BEAT_BASE(8)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .play_btn  (play_btn),
        .stop_btn  (stop_btn),
        .next_btn  (next_btn),
        .speed_sel (speed_sel),
        .loop_en   (loop_en),
        .note_data (note_data),
        .rom_addr  (rom_addr),
        .freq      (freq),
        .index     (index),
        .name      (name),
        .mode      (mode),
        .speed     (speed),
        .color     (color)
    );

    always #5 clk = ~clk;

    always @(posedge clk) note_data <= rom[rom_addr];

    task automatic chk(input string tag, input int obs, input int want);
        vecs++;
        assert (obs === want) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 0 = play, 1 = stop, 2 = next; returns at the first observation after capture
    task automatic press(input int which);
        if (which == 0) play_btn = 1'b1;
        if (which == 1) stop_btn = 1'b1;
        if (which == 2) next_btn = 1'b1;
        @(negedge clk);
        play_btn = 1'b0;
        stop_btn = 1'b0;
        next_btn = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) rom[a] = 8'h00;
        for (int s = 0; s < 4; s++) begin
            rom[s*2048 + 0] = 8'hA2;
            rom[s*2048 + 1] = 8'h11;
            rom[s*2048 + 2] = 8'h00;
        end
        clrn = 1'b0; play_btn = 1'b0; stop_btn = 1'b0; next_btn = 1'b0;
        speed_sel = 2'b00; loop_en = 1'b0;

        tick(2);
        chk("rst_freq", freq, 0);
        chk("rst_mode", mode, 0);
        chk("rst_index", index, 0);
        chk("rst_name", name, 0);
        chk("rst_speed", speed, 0);
        chk("rst_color", color, 0);
        chk("rst_addr", rom_addr, 0);
        clrn = 1'b1;
        tick(2);
        chk("idle_mode", mode, 0);

        // Song 0, no loop: 440 x 2 beats, 262 x 1 beat, end marker
        press(0);
        chk("t24_fetch_mode", mode, 1);
        chk("t24_fetch_freq", freq, 0);
        tick(1);
        chk("t24_decode_mode", mode, 1);
        tick(1);
        for (int k = 2; k <= 17; k++) begin
            chk("t24_f440", freq, 440);
            if (k == 9)  chk("t24_color_b1", color, 0);
            if (k == 10) chk("t24_color_b2", color, 1);
            tick(1);
        end
        chk("t24_idx1", index, 1);
        chk("t24_fetch2_mode", mode, 1);
        tick(2);
        for (int k = 20; k <= 27; k++) begin
            chk("t24_f262", freq, 262);
            tick(1);
        end
        chk("t24_idx2", index, 2);
        chk("t24_color3", color, 1);
        tick(2);
        chk("t24_end_mode", mode, 0);
        chk("t24_end_freq", freq, 0);
        chk("t24_end_index", index, 0);
        chk("t24_end_color", color, 0);

        // Loop enabled: marker at k=30 restarts at index 0, 440 back at k=32
        loop_en = 1'b1;
        press(0);
        tick(30);
        chk("t25_loop_mode", mode, 1);
        chk("t25_loop_index", index, 0);
        tick(2);
        chk("t25_loop_freq", freq, 440);
        chk("t25_loop_mode2", mode, 1);
        press(1);
        chk("t25_stop_mode", mode, 0);
        chk("t25_stop_freq", freq, 0);
        chk("t25_stop_index", index, 0);
        loop_en = 1'b0;

        // Pause with the timer at 5, hold 20 cycles, resume for the remaining 11
        press(0);
        tick(7);
        chk("t26_pre_freq", freq, 440);
        press(0);
        for (int k = 8; k <= 27; k++) begin
            chk("t26_pause_mode", mode, 2);
            chk("t26_pause_freq", freq, 0);
            chk("t26_pause_color", color, 0);
            if (k < 27) tick(1);
        end
        press(0);
        for (int k = 28; k <= 38; k++) begin
            chk("t26_resume_freq", freq, 440);
            chk("t26_resume_mode", mode, 1);
            if (k == 30) chk("t26_color_hold", color, 0);
            if (k == 31) chk("t26_color_tog", color, 1);
            tick(1);
        end
        chk("t26_next_index", index, 1);
        chk("t26_next_color", color, 0);
        press(1);
        chk("t26_stop_mode", mode, 0);

        // Tempo change 00 -> 10 with timer at 5
        press(0);
        tick(7);
        speed_sel = 2'b10;
        tick(1);
        chk("t27_speed", speed, 2);
        chk("t27_color_pre", color, 0);
        tick(1);
        chk("t27_beat_end", color, 1);
        tick(1);
        chk("t27_b2_color", color, 1);
        chk("t27_b2_index", index, 0);
        tick(1);
        chk("t27_b2_done_idx", index, 1);
        chk("t27_b2_done_col", color, 0);
        tick(2);
        chk("t27_n2_freq", freq, 262);
        tick(1);
        chk("t27_n2_index", index, 1);
        tick(1);
        chk("t27_n2_done_idx", index, 2);
        chk("t27_n2_done_col", color, 1);
        tick(2);
        chk("t27_end_mode", mode, 0);
        speed_sel = 2'b00;

        // Select song 3, then simultaneous stop/next/play during PLAY
        press(2);
        chk("t28_name1", name, 1);
        press(2);
        chk("t28_name2", name, 2);
        press(2);
        chk("t28_name3", name, 3);
        chk("t28_mode_stop", mode, 0);
        chk("t28_addr", rom_addr, 6144);
        press(0);
        tick(2);
        chk("t28_play_freq", freq, 440);
        play_btn = 1'b1; stop_btn = 1'b1; next_btn = 1'b1;
        tick(1);
        play_btn = 1'b0; stop_btn = 1'b0; next_btn = 1'b0;
        chk("t28_all_mode", mode, 0);
        chk("t28_all_name", name, 3);
        chk("t28_all_freq", freq, 0);
        chk("t28_all_index", index, 0);

        // Song 2 at index 1, asynchronous reset mid-note
        press(2);
        press(2);
        press(2);
        chk("t29_name", name, 2);
        press(0);
        tick(20);
        chk("t29_idx", index, 1);
        chk("t29_freq", freq, 262);
        tick(2);
        clrn = 1'b0;
        #1;
        chk("t29_async_freq", freq, 0);
        chk("t29_async_mode", mode, 0);
        chk("t29_async_index", index, 0);
        chk("t29_async_name", name, 0);
        chk("t29_async_color", color, 0);
        chk("t29_async_addr", rom_addr, 0);
        @(negedge clk);
        clrn = 1'b1;
        tick(3);
        chk("t29_after_mode", mode, 0);
        chk("t29_after_freq", freq, 0);

        // The first edge after release must already sample play_btn
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        press(0);
        chk("t29_first_edge_mode", mode, 1);
        chk("t29_first_edge_idx", index, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/music_player_ctrl.md
MUSIC_PLAYER_CTRL -- requirements
Module: music_player_ctrl

Interface
REQ-001 SHALL provide parameter BEAT_BASE, default 12_500_000, clk cycles per beat at speed 00.
REQ-002 SHALL have ports (clock and reset first):
- clk, in, 1: system clock, 50 MHz.
- clrn, in, 1: reset, asynchronous and active-low.
- play_btn, in, 1: one-cycle debounced pulse that toggles play/pause.
- stop_btn, in, 1: one-cycle pulse that stops playback.
- next_btn, in, 1: one-cycle pulse that selects the next song.
- speed_sel, in, 2: tempo select.
- loop_en, in, 1: repeat the song at its end.
- note_data, in, 8: song ROM word; [7:4] pitch code, [3:0] beats.
- rom_addr, out, 13: song ROM address, always {name, index}.
- freq, out, 16: tone frequency in Hz; 0 means silent.
- index, out, 11: note position within the song.
- name, out, 2: song number.
- mode, out, 2: 00 STOP, 01 PLAY, 10 PAUSE.
- speed, out, 2: registered speed_sel.
- color, out, 1: beat blink.

Function
REQ-003 SHALL treat the ROM as synchronous: note_data is valid one cycle after rom_addr changes.
REQ-004 SHALL implement states STOP, FETCH, DECODE, PLAY and PAUSE; the mode output is 00 in STOP, 10 in PAUSE and 01 in all other states.
REQ-005 STOP: play_btn -> FETCH with index=0; next_btn -> name+1 (wrap 3->0), index=0, stay in STOP; freq=0 and color=0.
REQ-006 FETCH SHALL last exactly 1 cycle, then go to DECODE.
REQ-007 DECODE SHALL sample note_data as follows:
- note_data==8'h00 is the end marker: if loop_en=1, set index=0 and go to FETCH; else set index=0, freq=0 and go to STOP.
- Otherwise, load freq from the pitch table, load the beat count (beats 0 is treated as 1), clear the beat timer, and go to PLAY.
REQ-008 The pitch table SHALL map codes as follows:
- code 0 = 0 (rest).
- codes 1-12 = 262,277,294,311,330,349,370,392,415,440,466,494.
- codes 13-15 = 523,587,659.
REQ-009 The beat length SHALL be BEAT_BASE for speed 00, BEAT_BASE/2 for 01, BEAT_BASE/4 for 10 and BEAT_BASE*2 for 11.
REQ-010 The beat timer SHALL end a beat when timer >= beat_length-1, so a speed change mid-beat never overruns.
REQ-011 speed SHALL be registered from speed_sel every cycle.
REQ-012 PLAY: at each beat end, color SHALL toggle and the beat count SHALL decrement; when the last beat ends, index increments and the state goes to FETCH.
REQ-013 PLAY: if index==2047 when the last beat ends, the block SHALL treat it as the end marker, per REQ-007.
REQ-014 PLAY: play_btn -> PAUSE; the timer, beat count, index and color are held and freq output is 0.
REQ-015 PAUSE: play_btn -> PLAY, restoring the held note's freq and resuming the timer where it stopped.
REQ-016 In PLAY/FETCH/DECODE, next_btn -> name+1, index=0, FETCH; in PAUSE, next_btn -> name+1, index=0, STOP.
REQ-017 stop_btn in any state SHALL go to STOP with index=0, freq=0 and color=0; name is kept.
REQ-018 Simultaneous pulses SHALL be prioritised stop_btn > next_btn > play_btn; only the highest-priority pulse acts.
REQ-019 Latency: play_btn in STOP at edge N SHALL give FETCH after N, DECODE after N+1, and freq valid plus mode=01 after N+2.
REQ-020 All outputs SHALL be registered except rom_addr, which is a combinational concatenation of registers.

Reset
REQ-021 clrn low SHALL immediately force STOP with freq=0, index=0, name=0, speed=0, color=0, beat timer=0 and beat count=0, independent of clk.
REQ-022 Reset asserted mid-note SHALL discard all playback progress; after release the block waits in STOP for play_btn.
REQ-023 The first clk edge after clrn rises SHALL sample inputs normally.

Verification (BEAT_BASE=8, ROM modelled with 1-cycle latency)
REQ-024 Song 0 = {8'h A2, 8'h 11, 8'h00}, loop_en=0, speed 00, play_btn pulse -> freq=440 for 16 cycles, then 262 for 8 cycles, then freq=0, mode=00, index=0.
REQ-025 Same song with loop_en=1 -> after the 8'h00 marker, index returns to 0 and freq=440 again 2 cycles after the marker is decoded; mode stays 01.
REQ-026 play_btn 5 cycles into the 440 note, hold 20 cycles, play_btn again -> freq=0 and mode=10 during the hold; 440 then resumes and lasts the remaining 11 cycles, and color does not toggle while paused.
REQ-027 speed_sel 00 -> 10 mid-beat at timer=5 -> that beat ends on the next cycle and subsequent beats last 2 cycles.
REQ-028 stop_btn, next_btn and play_btn pulsed in the same cycle during PLAY with name=3 -> STOP, name stays 3, freq=0.
REQ-029 clrn low for 1 cycle during PLAY with name=2 and index=1 -> all outputs 0 asynchronously, and after release mode stays 00.
